prog_loader: RTL and testbench

- Writer-side counterpart of instruction fetch: streams a program image from the UART byte receiver into instruction memory's write port.
- Assembles little-endian 32-bit words from bytes.
- Drives word-addressed write strobes, and signals completion so the CPU can be released from upgrade mode.
- Sits between the UART RX block and the program ROM write port (upg_* interface).

---
 rtl/prog_loader.sv | 208 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Streams a program image received byte-by-byte from the UART
//             receiver into the instruction-memory write port. Assembles
//             little-endian 32-bit words, issues word-addressed write strobes,
//             verifies an 8-bit additive checksum and reports done / error.
//
//  Image    : LEN_LO, LEN_HI (word count N), 4*N data bytes, CSUM
//             CSUM = sum of the data bytes mod 256 (length bytes excluded).
//
//  Ports    : clk         system clock
//             rst         asynchronous active-high reset
//             start_i     one-cycle pulse, arms the loader when not busy
//             rx_data_i   received byte
//             rx_valid_i  one-cycle pulse, rx_data_i valid
//             upg_wen_o   one-cycle write strobe to instruction memory
//             upg_adr_o   word address of the current write
//             upg_dat_o   word data of the current write
//             upg_done_o  level, image written and checksum good
//             upg_err_o   level, load aborted (timeout, length, checksum)
//             busy_o      level, a load is in progress
//
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o,
    output logic              busy_o
);

    // Word counter is one bit wider than the address so it can hold N=2^ADDR_W.
    localparam int              c_CW         = ADDR_W + 1;
    localparam int              c_TW         = $clog2(TIMEOUT + 1);
    localparam logic [31:0]     c_MAX_WORDS  = 32'(1) << ADDR_W;
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_LO = 3'd1,
        S_WAIT_HI = 3'd2,
        S_DATA    = 3'd3,
        S_WAIT_CS = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t          r_state;
    logic [7:0]      r_len_lo;
    logic [15:0]     r_len;
    logic [c_CW-1:0] r_wcnt;    // index of the next word to be written
    logic [23:0]     r_buf;     // byte lanes 0..2; lane 3 goes straight out
    logic [1:0]      r_idx;
    logic [7:0]      r_csum;
    logic [c_TW-1:0] r_timer;

    logic [15:0]     w_len_rx;
    logic            w_len_bad;
    logic [c_CW-1:0] w_wcnt_nxt;
    logic            w_last_word;
    logic            w_timeout;

    assign w_len_rx    = {rx_data_i, r_len_lo};
    assign w_len_bad   = (w_len_rx == 16'd0) || ({16'd0, w_len_rx} > c_MAX_WORDS);
    assign w_wcnt_nxt  = r_wcnt + 1'b1;
    assign w_last_word = (32'(w_wcnt_nxt) == {16'd0, r_len});
    // Timer counts idle cycles since the last byte; this is the last idle
    // cycle allowed before the load is abandoned.
    assign w_timeout   = (r_timer == c_TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_wcnt     <= '0;
            r_buf      <= 24'd0;
            r_idx      <= 2'd0;
            r_csum     <= 8'd0;
            r_timer    <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= 32'd0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            upg_wen_o <= 1'b0;

            case (r_state)
                // Bytes arriving while not busy are dropped, including one
                // coinciding with start_i.
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        r_state    <= S_WAIT_LO;
                        r_timer    <= '0;
                        upg_done_o <= 1'b0;
                        upg_err_o  <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end

                // No timeout here: the host may take as long as it likes to
                // begin sending.
                S_WAIT_LO: begin
                    if (rx_valid_i) begin
                        r_len_lo <= rx_data_i;
                        r_timer  <= '0;
                        r_state  <= S_WAIT_HI;
                    end
                end

                S_WAIT_HI: begin
                    if (rx_valid_i) begin
                        r_timer <= '0;
                        r_len   <= w_len_rx;
                        if (w_len_bad) begin
                            r_state   <= S_ERR;
                            upg_err_o <= 1'b1;
                            busy_o    <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_wcnt  <= '0;
                            r_idx   <= 2'd0;
                            r_csum  <= 8'd0;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        upg_err_o <= 1'b1;
                        busy_o    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DATA: begin
                    if (rx_valid_i) begin
                        r_timer <= '0;
                        r_csum  <= r_csum + rx_data_i;
                        r_idx   <= r_idx + 1'b1;
                        case (r_idx)
                            2'd0:    r_buf[7:0]   <= rx_data_i;
                            2'd1:    r_buf[15:8]  <= rx_data_i;
                            2'd2:    r_buf[23:16] <= rx_data_i;
                            default: begin
                                // Word complete: present it with a strobe on
                                // the next cycle; adr/dat then hold until the
                                // following strobe.
                                upg_wen_o <= 1'b1;
                                upg_adr_o <= r_wcnt[ADDR_W-1:0];
                                upg_dat_o <= {rx_data_i, r_buf};
                                r_wcnt    <= w_wcnt_nxt;
                                if (w_last_word) begin
                                    r_state <= S_WAIT_CS;
                                end
                            end
                        endcase
                    end else if (w_timeout) begin
                        // Partial word is simply abandoned; no strobe.
                        r_state   <= S_ERR;
                        upg_err_o <= 1'b1;
                        busy_o    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WAIT_CS: begin
                    if (rx_valid_i) begin
                        r_timer <= '0;
                        busy_o  <= 1'b0;
                        if (rx_data_i == r_csum) begin
                            r_state    <= S_DONE;
                            upg_done_o <= 1'b1;
                        end else begin
                            r_state   <= S_ERR;
                            upg_err_o <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_ERR;
                        upg_err_o <= 1'b1;
                        busy_o    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader. Expected writes are queued
//             as bytes are sent and matched against each write strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int c_ADDR_W  = 14;
    localparam int c_TIMEOUT = 50;

    logic                clk;
    logic                rst;
    logic                start;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                upg_wen;
    logic [c_ADDR_W-1:0] upg_adr;
    logic [31:0]         upg_dat;
    logic                upg_done;
    logic                upg_err;
    logic                busy;

    prog_loader #(
        .ADDR_W  (c_ADDR_W),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .upg_wen_o  (upg_wen),
        .upg_adr_o  (upg_adr),
        .upg_dat_o  (upg_dat),
        .upg_done_o (upg_done),
        .upg_err_o  (upg_err),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_ADDR_W-1:0] adr;
        logic [31:0]         dat;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        cs_bad;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    wr_t                 exp_q[$];
    int                  n_tests = 0;
    int                  n_fail  = 0;
    logic [7:0]          tb_csum;
    logic [c_ADDR_W-1:0] tb_adr;
    vec_t                vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (upg_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got adr %0h dat %0h expected no write (t=%0t)",
                         upg_adr, upg_dat, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_adr", 64'(upg_adr), 64'(e.adr));
                check("wr_dat", 64'(upg_dat), 64'(e.dat));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b       = w[8*k +: 8];
            tb_csum = tb_csum + b;
            if (k == 3) begin
                exp_q.push_back('{adr: tb_adr, dat: w});
                tb_adr = tb_adr + 1'b1;
            end
            send_byte(b, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic begin_image();
        tb_csum = 8'd0;
        tb_adr  = '0;
    endtask

    initial begin
        logic [31:0] w;
        logic [15:0] i16;

        rst      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #1 rst = 1'b1;

        vt[0] = '{16'd2,      2, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
        vt[1] = '{16'd2,      2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
        vt[2] = '{16'h0000,   0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vt[3] = '{16'h4001,   0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
        vt[4] = '{16'd1,      1, 32'hA5A50F0F, 32'h0,        1'b0, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_wen",  64'(upg_wen),  64'd0);
        check("rst_adr",  64'(upg_adr),  64'd0);
        check("rst_dat",  64'(upg_dat),  64'd0);
        check("rst_done", 64'(upg_done), 64'd0);
        check("rst_err",  64'(upg_err),  64'd0);
        check("rst_busy", 64'(busy),     64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- start with coincident byte (dropped) ----------------
        begin_image();
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(posedge clk); #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(tb_csum, 0);
        check("coinc_done", 64'(upg_done), 64'd1);
        check("coinc_err",  64'(upg_err),  64'd0);
        check("coinc_adr",  64'(upg_adr),  64'd0);

        // ---------------- table-driven images ----------------
        for (int i = 0; i < 5; i++) begin
            pulse_start();
            check("tbl_busy_arm", 64'(busy), 64'd1);
            begin_image();
            send_byte(vt[i].len[7:0], int'($urandom_range(0, 3)));
            send_byte(vt[i].len[15:8], 0);
            if (vt[i].nw > 0) begin
                for (int j = 0; j < vt[i].nw; j++) begin
                    send_word((j == 0) ? vt[i].w0 : vt[i].w1, 3);
                end
                send_byte(vt[i].cs_bad ? ~tb_csum : tb_csum, 0);
            end
            check("tbl_done", 64'(upg_done), 64'(vt[i].exp_done));
            check("tbl_err",  64'(upg_err),  64'(vt[i].exp_err));
            check("tbl_busy", 64'(busy),     64'd0);
            check("tbl_q",    64'(exp_q.size()), 64'd0);
        end

        // ---------------- inter-byte timeout ----------------
        pulse_start();
        begin_image();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (c_TIMEOUT - 1) @(posedge clk);
        #1;
        check("to_err_early",  64'(upg_err), 64'd0);
        check("to_busy_early", 64'(busy),    64'd1);
        @(posedge clk); #1;
        check("to_err",  64'(upg_err), 64'd1);
        check("to_busy", 64'(busy),    64'd0);

        // recovery, with a start pulse while busy that must be ignored
        pulse_start();
        begin_image();
        send_byte(8'h01, 2);
        send_byte(8'h00, 0);
        pulse_start();
        send_word(32'h0BADF00D, 2);
        send_byte(tb_csum, 0);
        check("rec_done", 64'(upg_done), 64'd1);
        check("rec_err",  64'(upg_err),  64'd0);

        // ---------------- back-to-back bytes, 11 consecutive cycles ----------------
        pulse_start();
        begin_image();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h01020304, 0);
        send_word(32'hF0E0D0C0, 0);
        send_byte(tb_csum, 0);
        check("b2b_done", 64'(upg_done), 64'd1);
        check("b2b_q",    64'(exp_q.size()), 64'd0);

        // ---------------- maximum length 0x4000 ----------------
        pulse_start();
        begin_image();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        for (int i = 0; i < 16384; i++) begin
            i16 = 16'(i);
            w   = {i16 ^ 16'hA5A5, ~i16};
            send_word(w, 0);
        end
        send_byte(tb_csum, 0);
        check("max_done",    64'(upg_done), 64'd1);
        check("max_last_adr", 64'(upg_adr), 64'h3FFF);
        check("max_q",       64'(exp_q.size()), 64'd0);

        // ---------------- asynchronous reset mid-word ----------------
        pulse_start();
        begin_image();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_wen",  64'(upg_wen),  64'd0);
        check("arst_adr",  64'(upg_adr),  64'd0);
        check("arst_dat",  64'(upg_dat),  64'd0);
        check("arst_done", 64'(upg_done), 64'd0);
        check("arst_err",  64'(upg_err),  64'd0);
        check("arst_busy", 64'(busy),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i * 37 + 1), 0);
        end
        check("post_busy", 64'(busy),     64'd0);
        check("post_done", 64'(upg_done), 64'd0);
        check("post_err",  64'(upg_err),  64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("final_q", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
